// File: rtl/avalon_aes_pkg.sv
// Shared types and address map for the AES Avalon-MM register bank.
package avalon_aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int GO_BIT     = 0;
  localparam int IRQ_EN_BIT = 1;
  localparam int DONE_BIT   = 0;

  function automatic int key_base();
    return 0;
  endfunction

  function automatic int msg_base(input int key_words);
    return key_words;
  endfunction

  function automatic int pt_base(input int key_words, input int msg_words);
    return key_words + msg_words;
  endfunction

  function automatic int start_addr(input int addr_w);
    return (1 << addr_w) - 2;
  endfunction

  function automatic int done_addr(input int addr_w);
    return (1 << addr_w) - 1;
  endfunction

endpackage

// File: rtl/avalon_be_reg.sv
// One byte-lane-writable register with a full-width load path that has priority.
module avalon_be_reg #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [DATA_W/8-1:0] byte_en,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                load,
  input  logic [DATA_W-1:0]   load_data,
  output logic [DATA_W-1:0]   q
);

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (wr_en) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (byte_en[i]) q[8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/avalon_aes_regbank.sv
// Avalon-MM slave register bank for the AES decryption core with a START/DONE handshake.
module avalon_aes_regbank
  import avalon_aes_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int KEY_WORDS = 4,
  parameter int MSG_WORDS = 4
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          AVL_READ,
  input  logic                          AVL_WRITE,
  input  logic                          AVL_CS,
  input  logic [DATA_W/8-1:0]           AVL_BYTE_EN,
  input  logic [ADDR_W-1:0]             AVL_ADDR,
  input  logic [DATA_W-1:0]             AVL_WRITEDATA,
  output logic [DATA_W-1:0]             AVL_READDATA,
  output logic [DATA_W-1:0]             EXPORT_DATA,
  output logic [KEY_WORDS*DATA_W-1:0]   CORE_KEY,
  output logic [MSG_WORDS*DATA_W-1:0]   CORE_MSG_EN,
  output logic                          CORE_START,
  input  logic                          CORE_DONE,
  input  logic [MSG_WORDS*DATA_W-1:0]   CORE_MSG_DE,
  output logic                          IRQ
);

  localparam logic [ADDR_W-1:0] START_A = ADDR_W'(start_addr(ADDR_W));
  localparam logic [ADDR_W-1:0] DONE_A  = ADDR_W'(done_addr(ADDR_W));
  localparam int KEY_B = key_base();
  localparam int MSG_B = msg_base(KEY_WORDS);
  localparam int PT_B  = pt_base(KEY_WORDS, MSG_WORDS);

  logic              wr, rd, go, ack, start_d, capture, irq_en;
  logic [DATA_W-1:0] rd_mux;
  logic [DATA_W-1:0] key_q [KEY_WORDS];
  logic [DATA_W-1:0] msg_q [MSG_WORDS];
  logic [DATA_W-1:0] pt_q  [MSG_WORDS];
  state_t            state_q, state_d;

  assign wr  = AVL_WRITE & AVL_CS;
  assign rd  = AVL_READ & AVL_CS;
  assign go  = wr && (AVL_ADDR == START_A) && AVL_BYTE_EN[0] && AVL_WRITEDATA[GO_BIT];
  assign ack = wr && (AVL_ADDR == DONE_A) && AVL_BYTE_EN[0] && AVL_WRITEDATA[DONE_BIT];

  genvar g;
  generate
    for (g = 0; g < KEY_WORDS; g++) begin : g_key
      avalon_be_reg #(.DATA_W(DATA_W)) u_reg (
        .clk(CLK), .rst_n(RESET),
        .wr_en(wr && (AVL_ADDR == ADDR_W'(KEY_B + g))),
        .byte_en(AVL_BYTE_EN), .wr_data(AVL_WRITEDATA),
        .load(1'b0), .load_data('0), .q(key_q[g])
      );
      assign CORE_KEY[(KEY_WORDS-1-g)*DATA_W +: DATA_W] = key_q[g];
    end
    for (g = 0; g < MSG_WORDS; g++) begin : g_msg
      avalon_be_reg #(.DATA_W(DATA_W)) u_ct (
        .clk(CLK), .rst_n(RESET),
        .wr_en(wr && (AVL_ADDR == ADDR_W'(MSG_B + g))),
        .byte_en(AVL_BYTE_EN), .wr_data(AVL_WRITEDATA),
        .load(1'b0), .load_data('0), .q(msg_q[g])
      );
      assign CORE_MSG_EN[(MSG_WORDS-1-g)*DATA_W +: DATA_W] = msg_q[g];
      // Plaintext words are only ever loaded from the core, never from the bus.
      avalon_be_reg #(.DATA_W(DATA_W)) u_pt (
        .clk(CLK), .rst_n(RESET),
        .wr_en(1'b0), .byte_en('0), .wr_data('0),
        .load(capture),
        .load_data(CORE_MSG_DE[(MSG_WORDS-1-g)*DATA_W +: DATA_W]),
        .q(pt_q[g])
      );
    end
  endgenerate

  assign EXPORT_DATA = {key_q[0][DATA_W-1:DATA_W/2], key_q[KEY_WORDS-1][DATA_W/2-1:0]};
  assign IRQ = (state_q == DONE) & irq_en;

  always_ff @(posedge CLK) begin
    if (!RESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go) state_d = BUSY;
      BUSY:    if (CORE_DONE) state_d = DONE;
      DONE:    if (go) state_d = BUSY;
               else if (ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_d = go && (state_q != BUSY);
    capture = (state_q == BUSY) && CORE_DONE;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      CORE_START <= 1'b0;
      irq_en     <= 1'b0;
    end else begin
      CORE_START <= start_d;
      if (wr && (AVL_ADDR == START_A) && AVL_BYTE_EN[0]) irq_en <= AVL_WRITEDATA[IRQ_EN_BIT];
    end
  end

  // NOTE: rd_mux is defaulted first so no path through this block can infer a latch.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < KEY_WORDS; i++) if (AVL_ADDR == ADDR_W'(KEY_B + i)) rd_mux = key_q[i];
    for (int i = 0; i < MSG_WORDS; i++) begin
      if (AVL_ADDR == ADDR_W'(MSG_B + i)) rd_mux = msg_q[i];
      if (AVL_ADDR == ADDR_W'(PT_B + i))  rd_mux = pt_q[i];
    end
    if (AVL_ADDR == START_A) rd_mux[IRQ_EN_BIT] = irq_en;
    if (AVL_ADDR == DONE_A)  rd_mux[DONE_BIT]   = (state_q == DONE);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) AVL_READDATA <= '0;
    else        AVL_READDATA <= rd ? rd_mux : '0;
  end

endmodule

// File: doc/avalon_aes_regbank.md
# avalon_aes_regbank

Parametrised Avalon-MM slave register bank for the AES decryption core: software-visible key/ciphertext/plaintext words, byte-lane writes, one-cycle registered reads, and a START/DONE handshake FSM. It sits between the Platform Designer Avalon-MM interconnect and the AES core. The core receives a one-cycle start pulse, and the plaintext it returns is captured into read-only registers.

## Interface
Parameters:
- DATA_W, 32: register width; multiple of 8, at least 16.
- ADDR_W, 4: word-address width.
- KEY_WORDS, 4: key registers at addresses 0..KEY_WORDS-1.
- MSG_WORDS, 4: ciphertext registers at KEY_WORDS..KEY_WORDS+MSG_WORDS-1; plaintext registers follow at the next MSG_WORDS addresses.
- Constraint: KEY_WORDS + 2*MSG_WORDS <= 2^ADDR_W - 2. START is at 2^ADDR_W-2; DONE is at 2^ADDR_W-1.

Ports:
- CLK  in  1  sole clock; all state on rising edge.
- RESET  in  1  synchronous, active-low reset.
- AVL_READ  in  1  read request.
- AVL_WRITE  in  1  write request.
- AVL_CS  in  1  chip select; qualifies read and write.
- AVL_BYTE_EN  in  DATA_W/8  byte-lane enables for writes.
- AVL_ADDR  in  ADDR_W  word address.
- AVL_WRITEDATA  in  DATA_W  write data.
- AVL_READDATA  out  DATA_W  registered read data.
- EXPORT_DATA  out  DATA_W  LED conduit: {key0[DATA_W-1:DATA_W/2], key[KEY_WORDS-1][DATA_W/2-1:0]}.
- CORE_KEY  out  KEY_WORDS*DATA_W  key words; word 0 in the MSBs.
- CORE_MSG_EN  out  MSG_WORDS*DATA_W  ciphertext words; word 0 in the MSBs.
- CORE_START  out  1  one-cycle start pulse to the core.
- CORE_DONE  in  1  core completion strobe.
- CORE_MSG_DE  in  MSG_WORDS*DATA_W  plaintext; sampled on CORE_DONE.
- IRQ  out  1  level interrupt: DONE[0] & START[1].

## Operation
- Write when AVL_WRITE & AVL_CS. Byte lane i updates only if AVL_BYTE_EN[i]; other lanes hold. Any enable pattern, including 0000, is legal.
- Key, ciphertext and START registers are software-writable. Plaintext registers ignore bus writes. Unmapped addresses: writes ignored, reads return 0.
- START register: bit0 = GO (self-clearing, always reads 0); bit1 = IRQ_EN (read/write). Other bits read 0.
- DONE register: bit0 = DONE flag, read-only via the bus. A bus write with bit0=1 in an enabled lane is an acknowledge.
- FSM states:
  - IDLE: a GO write moves to BUSY and asserts CORE_START in the next cycle.
  - BUSY: CORE_DONE loads all plaintext registers from CORE_MSG_DE, sets DONE=1, moves to DONE. GO writes are ignored; IRQ_EN is still updated.
  - DONE: an acknowledge clears DONE and moves to IDLE. A GO write clears DONE, pulses CORE_START and moves to BUSY.
- CORE_DONE outside BUSY is ignored.
- CORE_DONE and an acknowledge in the same BUSY cycle: CORE_DONE wins; DONE=1.
- Reads when AVL_READ & AVL_CS; AVL_READDATA is 0 in any cycle following a non-read.
- Read and write to the same address in the same cycle: the read returns the pre-write value.

## Timing
- Reset (RESET=0 at an edge): all registers, AVL_READDATA, CORE_START and IRQ go to 0; FSM goes to IDLE.
  - Reset mid-BUSY aborts.
  - A late CORE_DONE after reset is ignored.
- Read latency is 1: data for a read presented at edge n appears after edge n and is valid at edge n+1.
- Writes are visible on CORE_KEY, CORE_MSG_EN and EXPORT_DATA one cycle after the write edge.
- CORE_START is high for exactly one cycle, the cycle after the GO write edge.
- DONE, IRQ and the plaintext registers update one cycle after the CORE_DONE edge.
- No wait states; the slave accepts one transfer per cycle.

## Structure
- Package avalon_aes_pkg holds:
  - the FSM state enum (IDLE, BUSY, DONE);
  - START/DONE bit-index constants (GO=0, IRQ_EN=1, DONE=0);
  - address-base functions of (KEY_WORDS, MSG_WORDS, ADDR_W).
- Sub-module avalon_be_reg: one DATA_W byte-enabled register with synchronous active-low clear. It is instantiated per key, ciphertext and plaintext word via a generate loop. Plaintext instances use a separate capture-load path with all lanes enabled.

## Test plan
- Full and partial writes:
  - Write 0x2B7E1516 to addr 0 with BYTE_EN=1111, then 0xFFFFFFFF with BYTE_EN=0100. Read addr 0 → 0x2BFF1516, one cycle after the read.
  - EXPORT_DATA → 0x2BFF_xxxx, low half from key word 3.
- GO in IDLE:
  - Write START=0x3 → CORE_START high for exactly 1 cycle; START reads 0x2.
  - Second GO while BUSY → no pulse.
- Completion:
  - CORE_DONE with CORE_MSG_DE=0xDAEC3055… → addrs 8–11 return those words; DONE reads 1; IRQ=1.
  - Write DONE=0x1 → DONE reads 0, IRQ=0, FSM IDLE.
- Protection:
  - Write 0xDEADBEEF to addr 8 and to addr 12 → reads return the previously captured value and 0 respectively.
- Simultaneous events and reset:
  - CORE_DONE coincident with a DONE ack in BUSY → DONE=1.
  - RESET=0 mid-BUSY, then CORE_DONE → all reads 0, no DONE set, CORE_START stays 0.
